// File: rtl/rr_priority_encoder_pkg.sv
// +--------------------------------------------------------------------------+
// | vkl_pkg : shared constants and helpers for the round-robin encoder        |
// | Rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

package vkl_pkg;

    parameter int N_DEFAULT = 16;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Ceiling log2, usable in parameter expressions; never below 1.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_priority_encoder_prio_find.sv
// +--------------------------------------------------------------------------+
// | prio_find : descending wrap-around search for the first set request bit   |
// | Rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module prio_find
    import vkl_pkg::*;
#(
    parameter  int N     = N_DEFAULT,
    localparam int IDX_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    input  logic             search_en,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    int cand;

    // Candidate j is start-j modulo N, so the first hit is the nearest below start.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        if (search_en) begin
            for (int j = 0; j < N; j++) begin
                cand = (int'(start) >= j) ? (int'(start) - j) : (int'(start) + N - j);
                if (!found && req[IDX_W'(cand)]) begin
                    found = 1'b1;
                    idx   = IDX_W'(cand);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rr_priority_encoder.sv
// +--------------------------------------------------------------------------+
// | rr_priority_encoder : registered fixed / round-robin arbiter with         |
// | valid/ready grant handshake.   Rev 1.0 : initial release                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module rr_priority_encoder
    import vkl_pkg::*;
#(
    parameter  int N     = N_DEFAULT,
    localparam int IDX_W = clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode_rr,
    input  logic [N-1:0]     req,
    input  logic             gnt_ready,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N-1:0]     gnt_onehot,
    output logic             none
);

    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(N - 1);

    logic             gnt_valid_q,  gnt_valid_d;
    logic [IDX_W-1:0] gnt_idx_q,    gnt_idx_d;
    logic [N-1:0]     gnt_onehot_q, gnt_onehot_d;
    logic             none_q,       none_d;
    logic [IDX_W-1:0] rr_ptr_q,     rr_ptr_d;

    logic             w_slot;
    logic             w_rr;
    logic [IDX_W-1:0] w_start;
    logic             w_found;
    logic [IDX_W-1:0] w_win_idx;

    assign w_slot  = !gnt_valid_q || gnt_ready;
    assign w_rr    = (mode_rr == MODE_RR);
    assign w_start = w_rr ? rr_ptr_q : c_LAST;

    prio_find #(
        .N         (N)
    ) u_prio_find (
        .req       (req),
        .start     (w_start),
        .search_en (en),
        .found     (w_found),
        .idx       (w_win_idx)
    );

    always_comb begin
        gnt_valid_d  = gnt_valid_q;
        gnt_idx_d    = gnt_idx_q;
        gnt_onehot_d = gnt_onehot_q;
        none_d       = none_q;
        rr_ptr_d     = rr_ptr_q;
        if (w_slot) begin
            if (!en) begin
                gnt_valid_d  = 1'b0;
                gnt_onehot_d = '0;
            end else if (w_found) begin
                gnt_valid_d  = 1'b1;
                gnt_idx_d    = w_win_idx;
                gnt_onehot_d = N'(1) << w_win_idx;
                none_d       = 1'b0;
                // The winner drops to lowest priority for the next round-robin search.
                if (w_rr) begin
                    rr_ptr_d = (w_win_idx == '0) ? c_LAST : (w_win_idx - IDX_W'(1));
                end
            end else begin
                gnt_valid_d  = 1'b0;
                gnt_onehot_d = '0;
                none_d       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_valid_q  <= 1'b0;
            gnt_idx_q    <= '0;
            gnt_onehot_q <= '0;
            none_q       <= 1'b1;
            rr_ptr_q     <= c_LAST;
        end else begin
            gnt_valid_q  <= gnt_valid_d;
            gnt_idx_q    <= gnt_idx_d;
            gnt_onehot_q <= gnt_onehot_d;
            none_q       <= none_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign gnt_valid  = gnt_valid_q;
    assign gnt_idx    = gnt_idx_q;
    assign gnt_onehot = gnt_onehot_q;
    assign none       = none_q;

endmodule

`default_nettype wire
